// File: rtl/regfile_reader_if.sv
// Control, register-file and output-stream signals of regfile_reader grouped as one bundle.
// master = the reader block, slave = its environment (control source, register file, sink).
interface regfile_reader_if #(
    parameter int WIDTH = 16,
    parameter int SIZE  = 8
);
    logic             start;
    logic [SIZE-1:0]  base;
    logic [SIZE:0]    count;
    logic             busy;
    logic             done;
    logic [SIZE-1:0]  rf_rd_address;
    logic [WIDTH-1:0] rf_rd_data;
    logic [SIZE-1:0]  rf_wr_address;
    logic [WIDTH-1:0] rf_wr_data;
    logic             rf_wr;
    logic [WIDTH-1:0] out_data;
    logic [SIZE-1:0]  out_addr;
    logic             out_valid;
    logic             out_ready;

    modport master (
        input  start, base, count, rf_rd_data, out_ready,
        output busy, done, rf_rd_address, rf_wr_address, rf_wr_data, rf_wr,
               out_data, out_addr, out_valid
    );

    modport slave (
        output start, base, count, rf_rd_data, out_ready,
        input  busy, done, rf_rd_address, rf_wr_address, rf_wr_data, rf_wr,
               out_data, out_addr, out_valid
    );
endinterface

// File: rtl/regfile_reader.sv
// Streams count registers from base out of a registered-read register file; first word valid 3 cycles after start, then >=3 cycles/word, held while out_ready is low.
// Optional REGFILE_READER_CLEAR_ON_READ_EN: each accepted word is zeroed in the register file (one extra write cycle per word).
module regfile_reader #(
    parameter int WIDTH = 16,
    parameter int SIZE  = 8
) (
    input  logic          clk,
    input  logic          nreset,
    regfile_reader_if.master bus
);
    typedef enum logic [2:0] {IDLE, ISSUE, LATCH, PRESENT, CLEAR, FINISH} state_t;

    state_t           state_q, state_d;
    logic [SIZE-1:0]  addr_q;
    logic [SIZE:0]    rem_q;
    logic [WIDTH-1:0] out_data_q;
    logic [SIZE-1:0]  out_addr_q;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            out_data_q <= '0;
            out_addr_q <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        addr_q <= bus.base;
                        rem_q  <= bus.count;
                    end
                end
                LATCH: begin
                    out_data_q <= bus.rf_rd_data;
                    out_addr_q <= addr_q;
                end
                PRESENT: begin
                    // address wraps naturally at 2^SIZE
                    if (bus.out_ready) begin
                        rem_q  <= rem_q - 1'b1;
                        addr_q <= addr_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.start) state_d = (bus.count != '0) ? ISSUE : FINISH;
            end
            ISSUE:   state_d = LATCH;
            LATCH:   state_d = PRESENT;
            PRESENT: begin
                if (bus.out_ready) begin
`ifdef REGFILE_READER_CLEAR_ON_READ_EN
                    state_d = CLEAR;
`else
                    state_d = (rem_q > (SIZE+1)'(1)) ? ISSUE : FINISH;
`endif
                end
            end
            // remaining was already decremented on acceptance
            CLEAR:   state_d = (rem_q != '0) ? ISSUE : FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy          = (state_q != IDLE);
    assign bus.done          = (state_q == FINISH);
    assign bus.out_valid     = (state_q == PRESENT);
    assign bus.out_data      = out_data_q;
    assign bus.out_addr      = out_addr_q;
    assign bus.rf_rd_address = addr_q;
    assign bus.rf_wr_data    = '0;

`ifdef REGFILE_READER_CLEAR_ON_READ_EN
    assign bus.rf_wr         = (state_q != CLEAR);
    assign bus.rf_wr_address = (state_q == CLEAR) ? out_addr_q : '0;
`else
    assign bus.rf_wr         = 1'b1;
    assign bus.rf_wr_address = '0;
`endif
endmodule

// File: tb/tb_regfile_reader.sv
// Scoreboard bench for regfile_reader with a registered-read register file model.
module tb_regfile_reader;
    localparam int WIDTH = 16;
    localparam int SIZE  = 8;
`ifdef REGFILE_READER_CLEAR_ON_READ_EN
    localparam int WORD_CYC = 4;
    localparam bit CLR      = 1'b1;
`else
    localparam int WORD_CYC = 3;
    localparam bit CLR      = 1'b0;
`endif

    logic clk    = 1'b0;
    logic nreset = 1'b0;
    always #5 clk = ~clk;

    regfile_reader_if #(.WIDTH(WIDTH), .SIZE(SIZE)) rif ();

    regfile_reader #(.WIDTH(WIDTH), .SIZE(SIZE)) dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (rif.master)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] init_val(input logic [7:0] a);
        case (a)
            8'd3:    return 16'h1111;
            8'd4:    return 16'h2222;
            8'd5:    return 16'h3333;
            default: return {a, a ^ 8'h5A};
        endcase
    endfunction

    // register file model: registered read, a write cycle suppresses the read
    logic [15:0] wval    [256];
    logic        written [256] = '{default: 1'b0};
    logic [15:0] rd_q = '0;
    assign rif.rf_rd_data = rd_q;

    always @(posedge clk) begin
        if (!rif.rf_wr) begin
            wval[rif.rf_wr_address]    <= rif.rf_wr_data;
            written[rif.rf_wr_address] <= 1'b1;
        end else begin
            rd_q <= written[rif.rf_rd_address] ? wval[rif.rf_rd_address] : init_val(rif.rf_rd_address);
        end
    end

    // bench's own knowledge of which registers clear-on-read has zeroed
    logic clr_mark [256] = '{default: 1'b0};

    function automatic logic [15:0] exp_val(input logic [7:0] a);
        return clr_mark[a] ? 16'h0000 : init_val(a);
    endfunction

    logic [23:0] exp_q[$];
    int done_cnt   = 0;
    int busy_cnt   = 0;
    int word_cnt   = 0;
    int wr_low_cnt = 0;
    logic        stall_q = 1'b0;
    logic [23:0] held    = '0;

    always @(negedge clk) begin
        if (!nreset) begin
            stall_q = 1'b0;
        end else begin
            if (rif.done)  done_cnt++;
            if (rif.busy)  busy_cnt++;
            if (!rif.rf_wr) wr_low_cnt++;
            if (stall_q)
                check_eq("hold", {7'd0, rif.out_valid, rif.out_addr, rif.out_data}, {7'd0, 1'b1, held});
            if (rif.out_valid) begin
                if (rif.out_ready) begin
                    word_cnt++;
                    if (exp_q.size() == 0) begin
                        check_eq("queue_nonempty", 32'(exp_q.size()), 32'd1);
                    end else begin
                        check_eq("word", {8'd0, rif.out_addr, rif.out_data}, {8'd0, exp_q.pop_front()});
                        if (CLR) clr_mark[rif.out_addr] = 1'b1;
                    end
                    stall_q = 1'b0;
                end else begin
                    stall_q = 1'b1;
                    held    = {rif.out_addr, rif.out_data};
                end
            end else begin
                stall_q = 1'b0;
            end
        end
    end

    task automatic start_xfer(input logic [7:0] b, input logic [8:0] c);
        logic [7:0] a;
        @(posedge clk); #1;
        done_cnt = 0; busy_cnt = 0; word_cnt = 0;
        rif.start = 1'b1; rif.base = b; rif.count = c;
        for (int i = 0; i < int'(c); i++) begin
            a = b + 8'(i);
            exp_q.push_back({a, exp_val(a)});
        end
        @(posedge clk); #1;
        rif.start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!rif.done && n < 500) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_done_seen"}, 32'(rif.done), 32'd1);
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!rif.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_valid_seen"}, 32'(rif.out_valid), 32'd1);
    endtask

    initial begin
        rif.start = 1'b0; rif.base = '0; rif.count = '0; rif.out_ready = 1'b1;
        nreset = 1'b0;
        repeat (2) @(posedge clk); #1;
        check_eq("rst_busy",      32'(rif.busy), 32'd0);
        check_eq("rst_done",      32'(rif.done), 32'd0);
        check_eq("rst_valid",     32'(rif.out_valid), 32'd0);
        check_eq("rst_out_data",  32'(rif.out_data), 32'd0);
        check_eq("rst_out_addr",  32'(rif.out_addr), 32'd0);
        check_eq("rst_rf_wr",     32'(rif.rf_wr), 32'd1);
        check_eq("rst_rd_addr",   32'(rif.rf_rd_address), 32'd0);
        check_eq("rst_wr_addr",   32'(rif.rf_wr_address), 32'd0);
        check_eq("rst_wr_data",   32'(rif.rf_wr_data), 32'd0);
        nreset = 1'b1;

        // three words from 3..5, latency of first word
        start_xfer(8'd3, 9'd3);
        @(negedge clk); check_eq("lat_c1", 32'(rif.out_valid), 32'd0);
        @(negedge clk); check_eq("lat_c2", 32'(rif.out_valid), 32'd0);
        @(negedge clk); check_eq("lat_c3", 32'(rif.out_valid), 32'd1);
        wait_done("basic");
        check_eq("basic_words", 32'(word_cnt), 32'd3);
        check_eq("basic_done",  32'(done_cnt), 32'd1);
        check_eq("basic_busy",  32'(busy_cnt), 32'(3 * WORD_CYC + 1));
        check_eq("basic_queue", 32'(exp_q.size()), 32'd0);

        // address wrap
        start_xfer(8'hFE, 9'd4);
        wait_done("wrap");
        check_eq("wrap_words", 32'(word_cnt), 32'd4);
        check_eq("wrap_done",  32'(done_cnt), 32'd1);
        check_eq("wrap_queue", 32'(exp_q.size()), 32'd0);

        // zero-length transfer
        start_xfer(8'h30, 9'd0);
        wait_done("zero");
        check_eq("zero_words", 32'(word_cnt), 32'd0);
        check_eq("zero_done",  32'(done_cnt), 32'd1);
        check_eq("zero_busy",  32'(busy_cnt), 32'd1);

        // backpressure with a start pulse while busy
        rif.out_ready = 1'b0;
        start_xfer(8'h10, 9'd2);
        wait_valid("bp");
        @(posedge clk); #1;
        rif.start = 1'b1; rif.base = 8'h80; rif.count = 9'd5;
        @(posedge clk); #1;
        rif.start = 1'b0;
        repeat (3) @(posedge clk); #1;
        rif.out_ready = 1'b1;
        wait_done("bp");
        check_eq("bp_words", 32'(word_cnt), 32'd2);
        check_eq("bp_done",  32'(done_cnt), 32'd1);
        check_eq("bp_queue", 32'(exp_q.size()), 32'd0);
        repeat (5) @(negedge clk);
        check_eq("bp_start_ignored", 32'(rif.busy), 32'd0);

        // reset while a word is presented
        rif.out_ready = 1'b0;
        start_xfer(8'h20, 9'd3);
        wait_valid("rst_mid");
        @(posedge clk); #1;
        nreset = 1'b0;
        #1;
        check_eq("rst_mid_valid", 32'(rif.out_valid), 32'd0);
        check_eq("rst_mid_busy",  32'(rif.busy), 32'd0);
        check_eq("rst_mid_rf_wr", 32'(rif.rf_wr), 32'd1);
        check_eq("rst_mid_done",  32'(rif.done), 32'd0);
        exp_q.delete();
        #5;
        nreset = 1'b1;
        rif.out_ready = 1'b1;
        repeat (10) @(negedge clk);
        check_eq("rst_mid_no_done", 32'(done_cnt), 32'd0);
        check_eq("rst_mid_idle",    32'(rif.busy), 32'd0);
        check_eq("wr_low_total",    32'(wr_low_cnt), CLR ? 32'd9 : 32'd0);

`ifdef REGFILE_READER_CLEAR_ON_READ_EN
        wr_low_cnt = 0;
        start_xfer(8'd3, 9'd2);
        wait_done("clr1");
        check_eq("clr_wr_low", 32'(wr_low_cnt), 32'd2);
        check_eq("clr1_words", 32'(word_cnt), 32'd2);
        start_xfer(8'd3, 9'd2);
        wait_done("clr2");
        check_eq("clr2_words", 32'(word_cnt), 32'd2);
        check_eq("clr2_queue", 32'(exp_q.size()), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_reader.md
REGFILE_READER -- requirements
Module: regfile_reader

Interface
REQ-001 SHALL have parameter WIDTH, default 16, register data width in bits.
REQ-002 SHALL have parameter SIZE, default 8, register address width in bits (2^SIZE registers).
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port nreset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  request a block transfer, sampled on the rising edge.
REQ-006 SHALL have port base  input  SIZE  first register address, sampled when start is accepted.
REQ-007 SHALL have port count  input  SIZE+1  number of registers to read (0..2^SIZE), sampled when start is accepted.
REQ-008 SHALL have port busy  output  1  high while a transfer is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse at transfer end.
REQ-010 SHALL have port rf_rd_address  output  SIZE  register file read address.
REQ-011 SHALL have port rf_rd_data  input  WIDTH  register file read data, registered, valid one cycle after the address while rf_wr is high.
REQ-012 SHALL have port rf_wr_address  output  SIZE  register file write address.
REQ-013 SHALL have port rf_wr_data  output  WIDTH  register file write data.
REQ-014 SHALL have port rf_wr  output  1  register file write strobe, active-low; a write cycle suppresses the read.
REQ-015 SHALL have port out_data  output  WIDTH  streamed register value.
REQ-016 SHALL have port out_addr  output  SIZE  address of out_data.
REQ-017 SHALL have port out_valid  output  1  out_data/out_addr valid.
REQ-018 SHALL have port out_ready  input  1  downstream accepts the word when high with out_valid.

Function
REQ-019 SHALL implement states IDLE, ISSUE, LATCH, PRESENT, CLEAR, FINISH.
REQ-020 SHALL, in IDLE with start=1, load address register with base and remaining counter with count, then go to ISSUE if count!=0, else to FINISH.
REQ-021 SHALL, in ISSUE, drive rf_rd_address=current address with rf_wr=1, then go to LATCH.
REQ-022 SHALL, in LATCH, keep rf_rd_address and rf_wr=1, load out_data<=rf_rd_data and out_addr<=current address at the cycle end, then go to PRESENT.
REQ-023 SHALL, in PRESENT, hold out_valid=1 with out_data/out_addr stable until out_valid&out_ready, then go to CLEAR if compiled in, else to ISSUE (remaining>1) or FINISH (remaining=1).
REQ-024 SHALL decrement remaining and increment the address modulo 2^SIZE on each accepted word; address 2^SIZE-1 wraps to 0.
REQ-025 SHALL, in FINISH, assert done=1 for exactly one cycle, then go to IDLE.
REQ-026 SHALL drive busy=1 in every state except IDLE.
REQ-027 SHALL ignore start while busy=1.
REQ-028 SHALL give first out_valid in the 3rd cycle after the start edge; a word takes minimum 3 cycles (4 with CLEAR).
REQ-029 SHALL keep rf_wr=1 in every state except CLEAR.
REQ-030 SHALL ignore out_ready outside PRESENT.

Reset
REQ-031 SHALL, on nreset=0, immediately enter IDLE with busy=0, done=0, out_valid=0, out_data=0, out_addr=0, rf_wr=1, rf_rd_address=0, rf_wr_address=0, rf_wr_data=0.
REQ-032 SHALL abandon any transfer in progress when reset occurs mid-operation, without emitting done and without issuing a write.

Configuration
REQ-033 SHALL, with macro REGFILE_READER_CLEAR_ON_READ_EN defined, in CLEAR drive rf_wr=0, rf_wr_address=out_addr, rf_wr_data=0 for exactly one cycle, then go to ISSUE or FINISH per REQ-023.
REQ-034 SHALL, without REGFILE_READER_CLEAR_ON_READ_EN, never enter CLEAR and hold rf_wr=1 permanently.

Verification
REQ-035 SHALL cover: regs 3..5 = 0x1111,0x2222,0x3333, base=3, count=3, out_ready=1 -> three words (3,0x1111),(4,0x2222),(5,0x3333), first valid 3 cycles after start, done pulse once.
REQ-036 SHALL cover: base=0xFE, count=4 -> out_addr sequence 0xFE,0xFF,0x00,0x01.
REQ-037 SHALL cover: count=0 -> no out_valid, done pulse one cycle after FINISH entry, busy high for 1 cycle.
REQ-038 SHALL cover: out_ready low 5 cycles during PRESENT -> out_valid/out_data held stable, no word lost or duplicated, start pulse during busy ignored.
REQ-039 SHALL cover: CLEAR_ON_READ_EN, base=3, count=2 -> words read, then regs 3,4 read back 0; rf_wr low exactly 2 cycles total.
REQ-040 SHALL cover: nreset pulsed in PRESENT -> out_valid=0, busy=0, rf_wr=1 immediately, no done.
